// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving active-low seven-segment digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_display_driver #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int SW = 4*DIGITS + 4;
  localparam int DW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [31:0] max_dec(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r * 32'd10 + 32'd9;
    return r;
  endfunction

  localparam logic [31:0] MAXV = max_dec(DIGITS);

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS + 1; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [DW-1:0] sat_digits(input logic ovf, input logic [DW-1:0] d);
    return ovf ? {DIGITS{4'h9}} : d;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0: r = 7'b1000000;
      4'd1: r = 7'b1111001;
      4'd2: r = 7'b0100100;
      4'd3: r = 7'b0110000;
      4'd4: r = 7'b0011001;
      4'd5: r = 7'b0010010;
      4'd6: r = 7'b0000010;
      4'd7: r = 7'b1111000;
      4'd8: r = 7'b0000000;
      4'd9: r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last_shift;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  logic [WIDTH-1:0] shreg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    scratch_nxt;
  logic [DW-1:0]    disp;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = CONVERT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_shift  = (state == CONVERT) && (cnt == CW'(1));
  assign scratch_nxt = (add3(scratch) << 1) | SW'(shreg[WIDTH-1]);

  // Conversion datapath: capture on accept, one add-3/shift step per CONVERT cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= value;
      scratch <= '0;
    end else if (state == CONVERT) begin
      shreg   <= shreg << 1;
      scratch <= scratch_nxt;
    end
  end

  // Control and committed display state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
    end else if (accept) begin
      cnt      <= CW'(WIDTH);
      ovf_pend <= 32'(value) > MAXV;
    end else if (state == CONVERT) begin
      cnt <= cnt - CW'(1);
      if (last_shift) begin
        disp     <= sat_digits(ovf_pend, scratch_nxt[DW-1:0]);
        overflow <= ovf_pend;
      end
    end
  end

  assign busy = (state == CONVERT);
  assign done = (state == DONE);

  // Segment decode straight from the display register
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic lead;
    hex  = '1;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp[4*i +: 4] != 4'd0) lead = 1'b0;
      if (enable && !(lead && i > 0)) hex[7*i +: 7] = seg(disp[4*i +: 4]);
    end
  end
`else
  always_comb begin
    hex = '1;
    for (int i = 0; i < DIGITS; i++)
      if (enable) hex[7*i +: 7] = seg(disp[4*i +: 4]);
  end
`endif

endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomized self-checking bench for bcd_display_driver against a decimal-arithmetic reference.
module tb_bcd_display_driver;

  localparam int W = 10;

  logic clk = 0;
  logic reset = 1;
  logic enable = 1;
  logic load4 = 0, load3 = 0;
  logic [W-1:0] value4 = '0, value3 = '0;
  logic busy4, done4, ovf4, busy3, done3, ovf3;
  logic [27:0] hex4;
  logic [20:0] hex3;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  bcd_display_driver #(.WIDTH(W), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .load(load4), .value(value4),
    .busy(busy4), .done(done4), .overflow(ovf4), .hex(hex4));

  bcd_display_driver #(.WIDTH(W), .DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load3), .value(value3),
    .busy(busy3), .done(done3), .overflow(ovf3), .hex(hex3));

  function automatic logic [41:0] model_hex(input int v, input int nd, input bit en);
    logic [41:0] r;
    int digs[6];
    int p, maxv, msd;
    bit sat;
    r = '0;
    maxv = 1;
    for (int i = 0; i < nd; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    sat = v > maxv;
    p = 1;
    msd = 0;
    for (int i = 0; i < nd; i++) begin
      digs[i] = sat ? 9 : (v / p) % 10;
      p = p * 10;
      if (digs[i] != 0) msd = i;
    end
    for (int i = 0; i < nd; i++) begin
      bit blank;
      blank = !en;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > msd) blank = 1'b1;
`endif
      r[7*i +: 7] = blank ? 7'h7f : seg_tab[digs[i]];
    end
    return r;
  endfunction

  function automatic bit model_ovf(input int v, input int nd);
    int maxv;
    maxv = 1;
    for (int i = 0; i < nd; i++) maxv = maxv * 10;
    return v > maxv - 1;
  endfunction

  task automatic sample(input int sel, output logic b, output logic d, output logic o,
                        output logic [41:0] h);
    b = sel ? busy3 : busy4;
    d = sel ? done3 : done4;
    o = sel ? ovf3 : ovf4;
    h = sel ? {21'b0, hex3} : {14'b0, hex4};
  endtask

  task automatic start(input int sel, input int v);
    if (sel != 0) begin load3 = 1; value3 = W'(v); end
    else          begin load4 = 1; value4 = W'(v); end
    @(posedge clk);
    #1;
    load3 = 0; load4 = 0;
    value3 = W'($urandom); value4 = W'($urandom);
  endtask

  task automatic follow(input int sel, input int v, input int inj, input string nm);
    logic b, d, o;
    logic [41:0] h, eh;
    bit berr;
    int nd;
    nd = sel ? 3 : 4;
    berr = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      sample(sel, b, d, o, h);
      if (b !== 1'b1 || d !== 1'b0) berr = 1;
      if (k == inj) begin
        if (sel != 0) begin load3 = 1; value3 = W'(900); end
        else          begin load4 = 1; value4 = W'(900); end
      end
      @(posedge clk);
      #1;
      load3 = 0; load4 = 0;
    end
    total++;
    if (berr) begin bad++; $display("FAIL %s busy-window v=%0d busy/done wrong during convert", nm, v); end
    @(negedge clk);
    sample(sel, b, d, o, h);
    eh = model_hex(v, nd, enable);
    total++;
    if (d !== 1'b1 || b !== 1'b0) begin
      bad++; $display("FAIL %s done-timing v=%0d got done=%b busy=%b want done=1 busy=0", nm, v, d, b);
    end
    total++;
    if (h !== eh) begin bad++; $display("FAIL %s hex v=%0d got %h want %h", nm, v, h, eh); end
    total++;
    if (o !== model_ovf(v, nd)) begin
      bad++; $display("FAIL %s overflow v=%0d got %b want %b", nm, v, o, model_ovf(v, nd));
    end
  endtask

  task automatic run_conv(input int sel, input int v, input string nm);
    @(negedge clk);
    start(sel, v);
    follow(sel, v, -1, nm);
  endtask

  task automatic test_reset;
    logic b, d, o;
    logic [41:0] h;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sample(s, b, d, o, h);
      total++;
      if (b !== 0 || d !== 0 || o !== 0) begin
        bad++; $display("FAIL reset-ctrl sel=%0d got busy=%b done=%b ovf=%b want 0 0 0", s, b, d, o);
      end
      total++;
      if (h !== model_hex(0, s ? 3 : 4, 1)) begin
        bad++; $display("FAIL reset-hex sel=%0d got %h want %h", s, h, model_hex(0, s ? 3 : 4, 1));
      end
    end
  endtask

  task automatic test_known;
    run_conv(0, 42, "known42");
    total++;
    if (hex4[6:0] !== 7'b0100100 || hex4[13:7] !== 7'b0011001) begin
      bad++; $display("FAIL known42-digits got %b %b want 0011001 0100100", hex4[13:7], hex4[6:0]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) run_conv(0, int'($urandom_range(0, 1023)), "random4");
    for (int i = 0; i < 6; i++) run_conv(1, int'($urandom_range(0, 1023)), "random3");
  endtask

  task automatic test_overflow;
    run_conv(1, 1023, "ovf1023");
    run_conv(1, 5, "after-ovf5");
    run_conv(1, 999, "edge999");
    run_conv(1, 1000, "edge1000");
    run_conv(0, 0, "zero");
  endtask

  task automatic test_ignored_load;
    @(negedge clk);
    start(0, 7);
    follow(0, 7, 2, "ignored-load");
    start(0, 900);
    follow(0, 900, -1, "done-cycle-load");
  endtask

  task automatic test_back_to_back;
    int v, nv;
    v = int'($urandom_range(0, 1023));
    @(negedge clk);
    start(0, v);
    for (int i = 0; i < 5; i++) begin
      follow(0, v, -1, "back2back");
      nv = int'($urandom_range(0, 1023));
      start(0, nv);
      v = nv;
    end
    follow(0, v, -1, "back2back-last");
  endtask

  task automatic test_reset_abort;
    logic b, d, o;
    logic [41:0] h;
    bit seen;
    @(negedge clk);
    start(0, 999);
    repeat (3) @(negedge clk);
    reset = 1; load4 = 1; value4 = W'(321);
    @(posedge clk);
    #1 reset = 0; load4 = 0;
    @(negedge clk);
    sample(0, b, d, o, h);
    total++;
    if (b !== 0 || d !== 0 || o !== 0) begin
      bad++; $display("FAIL abort-ctrl got busy=%b done=%b ovf=%b want 0 0 0", b, d, o);
    end
    total++;
    if (h !== model_hex(0, 4, 1)) begin
      bad++; $display("FAIL abort-hex got %h want %h", h, model_hex(0, 4, 1));
    end
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done4 !== 1'b0 || busy4 !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort-quiet got activity after reset want none"); end
  endtask

  task automatic test_enable;
    run_conv(0, 1234 % 1024 + 0, "pre-enable");
    @(negedge clk);
    enable = 0;
    #1;
    total++;
    if (hex4 !== 28'hfffffff || hex3 !== 21'h1fffff) begin
      bad++; $display("FAIL enable-off got %h %h want all ones", hex4, hex3);
    end
    @(negedge clk);
    enable = 1;
    #1;
    total++;
    if (hex4 !== model_hex(1234 % 1024, 4, 1)) begin
      bad++; $display("FAIL enable-on got %h want %h", hex4, model_hex(1234 % 1024, 4, 1));
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_overflow();
    test_ignored_load();
    test_back_to_back();
    test_reset_abort();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
